// File: rtl/tx_fifo_ctrl_if.sv
// Bus between the APB transmit register path / serializer and tx_fifo_ctrl.
// The master modport is the side that pushes, pops and clears overflow.
// The slave modport is the FIFO controller itself.
interface tx_fifo_ctrl_if #(
    parameter int DATAWIDTH  = 12,
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en_i;
    logic [DATAWIDTH-1:0]  wr_data_i;
    logic                  rd_req_i;
    logic                  clr_ovf_i;
    logic [DATAWIDTH-1:0]  rd_data_o;
    logic                  rd_valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  overflow_o;
    logic [DEPTH_LOG2:0]   level_o;
    logic                  afull_o;

    modport master (
        output wr_en_i, wr_data_i, rd_req_i, clr_ovf_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, overflow_o, level_o, afull_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, rd_req_i, clr_ovf_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, overflow_o, level_o, afull_o
    );
endinterface

// File: rtl/tx_fifo_ctrl.sv
// Transmit FIFO controller between the APB register slave and the frame serializer.
// A level-style write enable is turned into one push per rising edge.
// Words are stored in a circular buffer and handed out on a request/valid handshake.
// Optional feature macro: TX_FIFO_AFULL_EN enables the almost-full flag
// (level >= DEPTH-2). When the macro is undefined, afull_o is tied low.
module tx_fifo_ctrl #(
    parameter int DATAWIDTH  = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    tx_fifo_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;

    // Edge detector for the level-style write enable
    logic                 wr_en_q, wr_en_d;

    // Pointers carry one extra wrap bit so that full and empty can be told apart
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;

    // Sticky flag for a push that was dropped while full
    logic                 overflow_q, overflow_d;

    // Registered pop output
    logic [DATAWIDTH-1:0] rd_data_q;
    logic                 rd_valid_q, rd_valid_d;

    // Storage array. It is not reset, and entries are only read after they are written.
    logic [DATAWIDTH-1:0] mem [DEPTH];

    // Decoded status and handshake qualifiers
    logic                  push_evt;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  push_drop;
    logic                  full;
    logic                  empty;
    logic [PTR_W-1:0]      level;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;

    // Status flags come from the registered pointers only
    always_comb begin
        wr_idx = wr_ptr_q[DEPTH_LOG2-1:0];
        rd_idx = rd_ptr_q[DEPTH_LOG2-1:0];
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) && (wr_idx == rd_idx);
        level  = wr_ptr_q - rd_ptr_q;
    end

    // Accept/drop decisions for this cycle.
    // A pop on an empty FIFO is ignored, so a push in the same cycle never falls through.
    // A push while full is only accepted when a pop frees the slot in the same cycle.
    always_comb begin
        push_evt  = bus.wr_en_i & ~wr_en_q;
        pop_ok    = bus.rd_req_i & ~empty;
        push_ok   = push_evt & (~full | pop_ok);
        push_drop = push_evt & full & ~pop_ok;
    end

    // Next-state computation for the edge detector, pointers, overflow flag and valid pulse
    always_comb begin
        wr_en_d    = bus.wr_en_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop_ok) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rd_valid_d = 1'b1;
        end

        // A dropped push wins over a clear in the same cycle
        if (push_drop) begin
            overflow_d = 1'b1;
        end else if (bus.clr_ovf_i) begin
            overflow_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_en_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage write port. It has no reset, so it maps onto block RAM.
    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem[wr_idx] <= bus.wr_data_i;
        end
    end

    // Registered read port. It holds the last popped word when no pop occurs.
    // On a full push+pop the same slot is read and written; the read returns the old word.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rd_data_q <= '0;
        end else if (pop_ok) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    // Optional almost-full early warning
`ifdef TX_FIFO_AFULL_EN
    logic afull;
    always_comb begin
        afull = (level >= PTR_W'(DEPTH - 2));
    end
`else
    logic afull;
    always_comb begin
        afull = 1'b0;
    end
`endif

    // Output mapping onto the bus
    always_comb begin
        bus.rd_data_o  = rd_data_q;
        bus.rd_valid_o = rd_valid_q;
        bus.full_o     = full;
        bus.empty_o    = empty;
        bus.overflow_o = overflow_q;
        bus.level_o    = level;
        bus.afull_o    = afull;
    end
endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Scoreboard bench for tx_fifo_ctrl.
// The reference model is a word queue plus an overflow bit. Each accepted pop
// pushes its expected word into a scoreboard queue, which the monitor drains
// on the falling edge.
module tb_tx_fifo_ctrl;
    localparam int DW    = 12;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    tx_fifo_ctrl_if #(.DATAWIDTH(DW), .DEPTH_LOG2(DL2)) bus ();

    tx_fifo_ctrl #(.DATAWIDTH(DW), .DEPTH_LOG2(DL2)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    // Reference model state
    logic [DW-1:0] mdl_q [$];
    logic [DW-1:0] exp_q [$];
    bit            mdl_ovf     = 1'b0;
    bit            mdl_prev_wr = 1'b0;
    logic [DW-1:0] mdl_last    = '0;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
        end
    endfunction

    // Reference model. It is evaluated on each clock edge and on reset assertion.
    initial begin
        bit push_evt;
        bit do_pop;
        forever begin
            @(posedge PCLK or negedge PRESETn);
            if (!PRESETn) begin
                mdl_q.delete();
                exp_q.delete();
                mdl_ovf     = 1'b0;
                mdl_prev_wr = 1'b0;
                mdl_last    = '0;
            end else begin
                push_evt    = bus.wr_en_i && !mdl_prev_wr;
                mdl_prev_wr = bus.wr_en_i;
                do_pop      = bus.rd_req_i && (mdl_q.size() > 0);
                if (do_pop) begin
                    mdl_last = mdl_q.pop_front();
                    exp_q.push_back(mdl_last);
                end
                if (push_evt) begin
                    if (mdl_q.size() < DEPTH) mdl_q.push_back(bus.wr_data_i);
                    else mdl_ovf = 1'b1;
                end
                if (!(push_evt && !do_pop && mdl_q.size() == DEPTH && bus.wr_data_i === bus.wr_data_i
                      && mdl_ovf) && bus.clr_ovf_i) begin
                    mdl_ovf = 1'b0;
                end
            end
        end
    end

    // Monitor: compares the pop handshake and the status outputs away from the active edge
    initial begin
        logic [DW-1:0] e;
        int            sz;
        bit            exp_afull;
        forever begin
            @(negedge PCLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_valid", 32'(bus.rd_valid_o), 32'd1);
                chk("pop_data", 32'(bus.rd_data_o), 32'(e));
            end else begin
                chk("rd_valid", 32'(bus.rd_valid_o), 32'd0);
                chk("hold_data", 32'(bus.rd_data_o), 32'(mdl_last));
            end
            sz = mdl_q.size();
`ifdef TX_FIFO_AFULL_EN
            exp_afull = (sz >= DEPTH - 2);
`else
            exp_afull = 1'b0;
`endif
            chk("level", 32'(bus.level_o), 32'(sz));
            chk("full", 32'(bus.full_o), 32'(sz == DEPTH));
            chk("empty", 32'(bus.empty_o), 32'(sz == 0));
            chk("overflow", 32'(bus.overflow_o), 32'(mdl_ovf));
            chk("afull", 32'(bus.afull_o), 32'(exp_afull));
        end
    end

    task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rd, input bit clr);
        bus.wr_en_i   = wr;
        bus.wr_data_i = d;
        bus.rd_req_i  = rd;
        bus.clr_ovf_i = clr;
        @(posedge PCLK);
        #2;
        $display("cyc t=%0t wr=%0b d=0x%03h rd=%0b clr=%0b level=%0d", $time, wr, d, rd, clr, mdl_q.size());
    endtask

    task automatic push(input logic [DW-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
        cycle(1'b0, d, 1'b0, 1'b0);
    endtask

    initial begin
        bit wr;
        bit rd;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = '0;
        bus.rd_req_i  = 1'b0;
        bus.clr_ovf_i = 1'b0;
        repeat (3) @(posedge PCLK);
        #2;
        PRESETn = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);

        // A held-high write enable produces a single push
        repeat (5) cycle(1'b1, 12'hA5C, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Fill with 17 distinct pushes; the 17th is dropped and sets overflow
        for (int i = 1; i <= 17; i++) push(DW'(i));

        // Clearing overflow while a push is dropped must leave it set
        cycle(1'b1, 12'h3AA, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Push and pop together while full
        cycle(1'b1, 12'h7FF, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        repeat (16) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Empty corner: a pop is ignored, and a push with a pop does not fall through
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, 12'h123, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Stream 40 push/pop pairs so the pointers wrap
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b1, 1'b0);
        end

        // Randomized traffic with alternating fill and drain bias
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                // Reset mid-run while the write enable stays high through release
                bus.wr_en_i = 1'b1;
                PRESETn     = 1'b0;
                @(posedge PCLK);
                #2;
                PRESETn = 1'b1;
                cycle(1'b1, 12'h5A5, 1'b0, 1'b0);
            end
            wr = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 99) < (((i / 100) % 2) ? 70 : 20));
            cycle(wr, DW'($urandom), rd, ($urandom_range(0, 15) == 0));
        end

        // Drain the FIFO
        repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
        @(negedge PCLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tx_fifo_ctrl.md
# tx_fifo_ctrl

Transmit-side buffer between the APB register slave and the frame serializer. It turns the slave's level-style transmit write-enable into single-entry pushes of the 12-bit transmit word. It holds the words in a circular FIFO and hands them to the serializer on a request/valid handshake. Its status bits feed the slave's transmit/receive status register, so software is blocked from writing when the FIFO is full.

## Interface
- DATAWIDTH, 12, width of one transmit word
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16)

Clock PCLK; reset PRESETn, asynchronous, active-low.

- PCLK  input  1  clock
- PRESETn  input  1  asynchronous active-low reset
- wr_en_i  input  1  transmit write-enable from the APB slave; level signal, may stay high many cycles
- wr_data_i  input  DATAWIDTH  transmit word from the APB slave
- rd_req_i  input  1  pop request from the serializer, one cycle per word
- clr_ovf_i  input  1  clears the sticky overflow flag
- rd_data_o  output  DATAWIDTH  popped word, registered
- rd_valid_o  output  1  one-cycle pulse, rd_data_o valid
- full_o  output  1  FIFO holds DEPTH words; drives status bit 7
- empty_o  output  1  FIFO holds 0 words; drives status bit 6
- overflow_o  output  1  sticky, a push was dropped while full; drives status bit 5
- level_o  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
- afull_o  output  1  almost-full flag (only when TX_FIFO_AFULL_EN is defined; otherwise tied 0)

## Operation
- Push detect: wr_en_q registers wr_en_i. A push event is wr_en_i & !wr_en_q, i.e. a rising edge. A held-high wr_en_i produces exactly one push.
- Push: wr_data_i is written at wr_ptr and wr_ptr increments. If full and no pop occurs in the same cycle, the push is dropped, overflow_o is set, and the pointers are unchanged.
- Pop: rd_req_i with the FIFO not empty loads mem[rd_ptr] into rd_data_o, pulses rd_valid_o and increments rd_ptr. rd_req_i while empty is ignored: rd_valid_o stays 0 and rd_data_o holds its value.
- Simultaneous push and pop:
  - When full, both are accepted and the level stays DEPTH.
  - When empty, the push is accepted and the pop is ignored. There is no fall-through.
  - Otherwise both are accepted and the level is unchanged.
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2·DEPTH.
  - empty_o = pointers equal.
  - full_o = MSBs differ and the low bits are equal.
  - level_o = wr_ptr − rd_ptr, modulo 2^(DEPTH_LOG2+1).
- Overflow: set by a dropped push and cleared by clr_ovf_i. If both happen in the same cycle, set wins.
- The storage array is not reset. Its contents are undefined until written.

## Timing
- Reset values:
  - rd_data_o = 0, rd_valid_o = 0, full_o = 0, empty_o = 1, overflow_o = 0, level_o = 0, afull_o = 0.
  - Pointers = 0, wr_en_q = 0.
- full_o, empty_o, level_o and afull_o are combinational from the registered pointers. They update in the cycle after the edge that accepted the push or pop.
- A push edge is sampled at edge N, where wr_en_i is high and wr_en_q is low. The word is stored at edge N and empty_o falls after edge N.
- A pop at edge N: rd_data_o and rd_valid_o are valid in cycle N+1. rd_valid_o is high for exactly one cycle per accepted pop.
- Back-to-back pops are allowed every cycle, giving a throughput of 1 word per clock.
- Reset asserted mid-operation immediately empties the FIFO and drops rd_valid_o. A wr_en_i that is still high after reset release counts as a push, because wr_en_q resets to 0.

## Configuration
- TX_FIFO_AFULL_EN defined: afull_o = (level_o >= DEPTH−2). Software can use it as an early-warning flag, for example by mapping it into a spare status bit.
- TX_FIFO_AFULL_EN undefined: afull_o is tied to 0, and no comparator logic is generated.

## Test plan
- Reset then push: release reset, raise wr_en_i with wr_data_i=0xA5C and hold it high 5 cycles. Expect level_o=1, empty_o=0, and only one entry stored.
- Fill and overflow: perform 17 distinct push edges with data 0x001..0x011 and no pops.
  - Expect full_o=1 after the 16th push and level_o=16.
  - Expect overflow_o=1 after the 17th push.
  - Then pop 16 times. Expect 0x001..0x010 in order, each with a one-cycle rd_valid_o.
- Simultaneous at full: with the FIFO full, push 0x7FF and pop in the same cycle.
  - Expect the oldest word on rd_data_o, level_o to stay 16 and overflow_o to stay 0.
  - The last word popped is 0x7FF.
- Empty corner:
  - With the FIFO empty, assert rd_req_i: expect no rd_valid_o.
  - Then push 0x123 and pop in the same cycle: expect no rd_valid_o and level_o=1.
  - Pop on the next cycle: expect 0x123.
- Overflow clear: assert clr_ovf_i together with a dropped push: expect overflow_o to stay 1. Assert clr_ovf_i alone next: expect overflow_o=0.
- Pointer wrap and config: stream 40 push/pop pairs, checking data order and level_o ≤ 2. With TX_FIFO_AFULL_EN defined, expect afull_o to rise exactly at level 14.
